// File: rtl/par_ser_pkg.sv
`default_nettype none
// ============================================================================
// Module   : par_ser_pkg
// Purpose  : Shared types and helpers for the CAN-XL/CAN-SEC parallel-to-
//            serial converter: FSM state encoding and word-length saturation.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package par_ser_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // A length of zero, or one larger than the word, means "full word".
  // This keeps the bit counter from ever being loaded with an
  // out-of-range value.
  function automatic int unsigned sat_len(input int unsigned len,
                                          input int unsigned max_len);
    if ((len == 0) || (len > max_len)) begin
      return max_len;
    end
    return len;
  endfunction

endpackage
`default_nettype wire

// File: rtl/par_ser_shift_reg.sv
`default_nettype none
// ============================================================================
// Module   : par_ser_shift_reg
// Purpose  : Load/shift register with a down-counting bit counter. A word is
//            loaded right-aligned; the register re-aligns it so that the bit
//            to be sent next is always at a fixed position (o_cur_bit).
// Ports    : clk        - system clock, rising edge
//            rst_n      - asynchronous reset, active low
//            i_clr      - synchronous flush (empties register and counter)
//            i_load     - load i_data/i_len (wins over i_shift)
//            i_data     - word, bits [i_len-1:0] significant
//            i_len      - bits in word, already saturated to 1..DATA_W
//            i_shift    - advance by one bit (ignored when counter is 0)
//            o_cur_bit  - bit that the next shift emits
//            o_word_end - counter is zero, no bits left in this word
//            o_last_bit - exactly one bit left in this word
// Revision : 1.0 - initial release
// ============================================================================
module par_ser_shift_reg
  import par_ser_pkg::*;
#(
  parameter int DATA_W    = 44,
  parameter int CNT_W     = $clog2(DATA_W + 1),
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_clr,
  input  logic              i_load,
  input  logic [DATA_W-1:0] i_data,
  input  logic [CNT_W-1:0]  i_len,
  input  logic              i_shift,
  output logic              o_cur_bit,
  output logic              o_word_end,
  output logic              o_last_bit
);

  logic [DATA_W-1:0] r_sh;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] w_load_val;
  logic [DATA_W-1:0] w_shift_val;

  generate
    if (MSB_FIRST) begin : g_msb_first
      // Left-justify so bit len-1 of the word lands on the MSB; bits above
      // len-1 fall off the top and are never sent.
      logic [CNT_W-1:0] w_pad;
      assign w_pad       = CNT_W'(DATA_W) - i_len;
      assign w_load_val  = i_data << w_pad;
      assign w_shift_val = {r_sh[DATA_W-2:0], 1'b0};
      assign o_cur_bit   = r_sh[DATA_W-1];
    end else begin : g_lsb_first
      // Bits above len-1 stay in the register but the counter stops
      // before they reach bit 0.
      assign w_load_val  = i_data;
      assign w_shift_val = {1'b0, r_sh[DATA_W-1:1]};
      assign o_cur_bit   = r_sh[0];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sh  <= '0;
      r_cnt <= '0;
    end else if (i_clr) begin
      r_sh  <= '0;
      r_cnt <= '0;
    end else if (i_load) begin
      r_sh  <= w_load_val;
      r_cnt <= i_len;
    end else if (i_shift && (r_cnt != '0)) begin
      r_sh  <= w_shift_val;
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign o_word_end = (r_cnt == '0);
  assign o_last_bit = (r_cnt == CNT_W'(1));

endmodule
`default_nettype wire

// File: rtl/par_ser_conv_xl.sv
`default_nettype none
// ============================================================================
// Module   : par_ser_conv_xl
// Purpose  : Parallel-to-serial converter for the CAN-XL/CAN-SEC TX path.
//            Serialises a frame of variable-length words, one bit per
//            bit_tick, and drives the PCRC generator controls. A one-word
//            holding buffer allows back-to-back words with no bit gap.
// Ports    : clk             - system clock, rising edge
//            g_rst_n         - asynchronous reset, active low
//            ld_valid/ready  - word handshake (ready registered)
//            ld_data/len/last- word, length (0 or >DATA_W = DATA_W), last flag
//            bit_tick        - one-clk strobe per bit time
//            tx_abort        - flush and return to IDLE (highest priority)
//            tx_success      - frame acknowledged, leaves DONE
//            tx_serial_out   - serial bit
//            tx_pcrc_intl    - PCRC init request, high in IDLE only
//            tx_pcrc_enable  - one pulse per emitted bit
//            tx_pcrc_frm_cmp - one pulse after the final bit of a frame
//            tx_underrun     - bit_tick with no bit available
//            busy            - high outside IDLE
// Revision : 1.0 - initial release
// ============================================================================
module par_ser_conv_xl
  import par_ser_pkg::*;
#(
  parameter int   DATA_W    = 44,
  parameter int   CNT_W     = $clog2(DATA_W + 1),
  parameter bit   MSB_FIRST = 1'b1,
  parameter logic IDLE_LVL  = 1'b0
) (
  input  logic              clk,
  input  logic              g_rst_n,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [DATA_W-1:0] ld_data,
  input  logic [CNT_W-1:0]  ld_len,
  input  logic              ld_last,
  input  logic              bit_tick,
  input  logic              tx_abort,
  input  logic              tx_success,
  output logic              tx_serial_out,
  output logic              tx_pcrc_intl,
  output logic              tx_pcrc_enable,
  output logic              tx_pcrc_frm_cmp,
  output logic              tx_underrun,
  output logic              busy
);

  state_e            r_state;
  state_e            w_nxt_state;

  // Holding buffer
  logic              r_hold_vld;
  logic [DATA_W-1:0] r_hold_data;
  logic [CNT_W-1:0]  r_hold_len;
  logic              r_hold_last;
  logic              w_nxt_hold_vld;
  logic              w_xfer;
  logic [CNT_W-1:0]  w_len_sat;

  // Word currently in the shifter is the last of its frame
  logic              r_cur_last;

  // Registered outputs
  logic              r_ld_ready;
  logic              r_serial;
  logic              r_intl;
  logic              r_pcrc_en;
  logic              r_frm_cmp;
  logic              r_underrun;
  logic              r_busy;

  // Output/datapath controls
  logic              w_emit;
  logic              w_sh_load;
  logic              w_hold_pop;
  logic              w_nxt_serial;
  logic              w_nxt_en;
  logic              w_nxt_frm;
  logic              w_nxt_und;

  // Shifter status
  logic              w_cur_bit;
  logic              w_word_end;
  logic              w_last_bit;

  par_ser_shift_reg #(
    .DATA_W    (DATA_W),
    .CNT_W     (CNT_W),
    .MSB_FIRST (MSB_FIRST)
  ) u_shift (
    .clk        (clk),
    .rst_n      (g_rst_n),
    .i_clr      (tx_abort),
    .i_load     (w_sh_load),
    .i_data     (r_hold_data),
    .i_len      (r_hold_len),
    .i_shift    (w_emit),
    .o_cur_bit  (w_cur_bit),
    .o_word_end (w_word_end),
    .o_last_bit (w_last_bit)
  );

  // A word offered while aborting is dropped.
  assign w_xfer    = ld_valid && r_ld_ready && !tx_abort;
  assign w_len_sat = CNT_W'(sat_len(32'(ld_len), DATA_W));

  // ------------------------------------------------------------------------
  // State register
  // ------------------------------------------------------------------------
  always_ff @(posedge clk or negedge g_rst_n) begin
    if (!g_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nxt_state;
    end
  end

  // ------------------------------------------------------------------------
  // Next-state logic
  // ------------------------------------------------------------------------
  always_comb begin
    w_nxt_state = r_state;
    case (r_state)
      ST_IDLE:  if (r_hold_vld) w_nxt_state = ST_LOAD;
      ST_LOAD:  w_nxt_state = ST_SHIFT;
      // The final bit was emitted last clk once the counter of a last word
      // has drained.
      ST_SHIFT: if (w_word_end && r_cur_last) w_nxt_state = ST_DONE;
      ST_DONE:  if (tx_success) w_nxt_state = ST_IDLE;
      default:  w_nxt_state = ST_IDLE;
    endcase
    if (tx_abort) begin
      w_nxt_state = ST_IDLE;
    end
  end

  // ------------------------------------------------------------------------
  // Output / datapath control logic
  // ------------------------------------------------------------------------
  always_comb begin
    w_emit       = 1'b0;
    w_sh_load    = 1'b0;
    w_hold_pop   = 1'b0;
    w_nxt_serial = r_serial;
    w_nxt_en     = 1'b0;
    w_nxt_frm    = 1'b0;
    w_nxt_und    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_nxt_serial = IDLE_LVL;
      end
      ST_LOAD: begin
        w_sh_load  = 1'b1;
        w_hold_pop = 1'b1;
      end
      ST_SHIFT: begin
        w_emit = bit_tick && !w_word_end;
        if (w_emit) begin
          w_nxt_serial = w_cur_bit;
          w_nxt_en     = 1'b1;
        end
        if (bit_tick && w_word_end) begin
          w_nxt_serial = IDLE_LVL;
          w_nxt_und    = !r_cur_last;
        end
        // Reload while the final bit of the current word is going out, so
        // the next tick finds the new word already in place; a word that
        // arrives after the shifter ran dry is picked up on the next clk.
        if (!r_cur_last && r_hold_vld && (w_word_end || (w_emit && w_last_bit))) begin
          w_sh_load  = 1'b1;
          w_hold_pop = 1'b1;
        end
        if (w_word_end && r_cur_last) begin
          w_nxt_frm = 1'b1;
        end
      end
      ST_DONE: begin
        if (bit_tick) w_nxt_serial = IDLE_LVL;
      end
      default: begin
        w_nxt_serial = IDLE_LVL;
      end
    endcase
    if (tx_abort) begin
      w_emit       = 1'b0;
      w_sh_load    = 1'b0;
      w_hold_pop   = 1'b0;
      w_nxt_serial = IDLE_LVL;
      w_nxt_en     = 1'b0;
      w_nxt_frm    = 1'b0;
      w_nxt_und    = 1'b0;
    end
  end

  // xfer and pop never coincide: xfer needs ready, which implies hold empty.
  assign w_nxt_hold_vld = tx_abort ? 1'b0 :
                          (w_xfer || (r_hold_vld && !w_hold_pop));

  // ------------------------------------------------------------------------
  // Holding buffer, current-word flag and registered outputs
  // ------------------------------------------------------------------------
  always_ff @(posedge clk or negedge g_rst_n) begin
    if (!g_rst_n) begin
      r_hold_vld  <= 1'b0;
      r_hold_data <= '0;
      r_hold_len  <= '0;
      r_hold_last <= 1'b0;
      r_cur_last  <= 1'b0;
      r_ld_ready  <= 1'b1;
      r_serial    <= IDLE_LVL;
      r_intl      <= 1'b1;
      r_pcrc_en   <= 1'b0;
      r_frm_cmp   <= 1'b0;
      r_underrun  <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_hold_vld <= w_nxt_hold_vld;
      if (tx_abort) begin
        r_hold_data <= '0;
        r_hold_len  <= '0;
        r_hold_last <= 1'b0;
        r_cur_last  <= 1'b0;
      end else begin
        if (w_xfer) begin
          r_hold_data <= ld_data;
          r_hold_len  <= w_len_sat;
          r_hold_last <= ld_last;
        end
        if (w_sh_load) begin
          r_cur_last <= r_hold_last;
        end
      end
      r_ld_ready <= !w_nxt_hold_vld && (w_nxt_state != ST_DONE);
      r_serial   <= w_nxt_serial;
      r_intl     <= (w_nxt_state == ST_IDLE);
      r_pcrc_en  <= w_nxt_en;
      r_frm_cmp  <= w_nxt_frm;
      r_underrun <= w_nxt_und;
      r_busy     <= (w_nxt_state != ST_IDLE);
    end
  end

  assign ld_ready        = r_ld_ready;
  assign tx_serial_out   = r_serial;
  assign tx_pcrc_intl    = r_intl;
  assign tx_pcrc_enable  = r_pcrc_en;
  assign tx_pcrc_frm_cmp = r_frm_cmp;
  assign tx_underrun     = r_underrun;
  assign busy            = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_par_ser_conv_xl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_par_ser_conv_xl
// Purpose  : Directed self-checking bench for par_ser_conv_xl. One MSB-first
//            instance carries most scenarios; an LSB-first instance shares
//            all inputs except ld_valid.
// Revision : 1.0 - initial release
// ============================================================================
module tb_par_ser_conv_xl;

  localparam int DATA_W = 44;
  localparam int CNT_W  = 6;

  logic              clk        = 1'b0;
  logic              g_rst_n    = 1'b1;
  logic              ld_valid   = 1'b0;
  logic              ld_valid_l = 1'b0;
  logic [DATA_W-1:0] ld_data    = '0;
  logic [CNT_W-1:0]  ld_len     = '0;
  logic              ld_last    = 1'b0;
  logic              bit_tick   = 1'b0;
  logic              tx_abort   = 1'b0;
  logic              tx_success = 1'b0;

  logic ld_ready, ser, intl, en, frm, und, busy;
  logic ld_ready_l, ser_l, intl_l, en_l, frm_l, und_l, busy_l;

  int n_vec = 0;
  int n_err = 0;
  int n_en  = 0;

  logic [DATA_W-1:0] w44;

  always #5 clk = ~clk;

  par_ser_conv_xl #(
    .DATA_W(DATA_W), .CNT_W(CNT_W), .MSB_FIRST(1'b1), .IDLE_LVL(1'b0)
  ) u_dut (
    .clk(clk), .g_rst_n(g_rst_n), .ld_valid(ld_valid), .ld_ready(ld_ready),
    .ld_data(ld_data), .ld_len(ld_len), .ld_last(ld_last), .bit_tick(bit_tick),
    .tx_abort(tx_abort), .tx_success(tx_success), .tx_serial_out(ser),
    .tx_pcrc_intl(intl), .tx_pcrc_enable(en), .tx_pcrc_frm_cmp(frm),
    .tx_underrun(und), .busy(busy)
  );

  par_ser_conv_xl #(
    .DATA_W(DATA_W), .CNT_W(CNT_W), .MSB_FIRST(1'b0), .IDLE_LVL(1'b0)
  ) u_dut_lsb (
    .clk(clk), .g_rst_n(g_rst_n), .ld_valid(ld_valid_l), .ld_ready(ld_ready_l),
    .ld_data(ld_data), .ld_len(ld_len), .ld_last(ld_last), .bit_tick(bit_tick),
    .tx_abort(tx_abort), .tx_success(tx_success), .tx_serial_out(ser_l),
    .tx_pcrc_intl(intl_l), .tx_pcrc_enable(en_l), .tx_pcrc_frm_cmp(frm_l),
    .tx_underrun(und_l), .busy(busy_l)
  );

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Offer one word and wait (bounded) until it is taken.
  task automatic load_word(input string tag, input bit sel,
                           input logic [DATA_W-1:0] d, input logic [CNT_W-1:0] l,
                           input logic last);
    logic ok;
    ok      = 1'b0;
    ld_data = d;
    ld_len  = l;
    ld_last = last;
    if (sel) ld_valid_l = 1'b1;
    else     ld_valid   = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if ((sel ? ld_ready_l : ld_ready) === 1'b1) begin
        ok = 1'b1;
        step();
        break;
      end
      step();
    end
    ld_valid   = 1'b0;
    ld_valid_l = 1'b0;
    chk({tag, "_accept"}, ok, 1'b1);
  endtask

  // One bit time: tick, check the emitting clk, then the clk after it
  // (where frm_cmp may pulse), then idle out the remaining clks (tick
  // period of 4 clk).
  task automatic tick_chk(input string tag, input bit sel, input logic exp_bit,
                          input logic exp_en, input logic exp_und, input logic exp_frm);
    bit_tick = 1'b1;
    step();
    bit_tick = 1'b0;
    chk({tag, "_ser"}, sel ? ser_l : ser, exp_bit);
    chk({tag, "_en"},  sel ? en_l  : en,  exp_en);
    chk({tag, "_und"}, sel ? und_l : und, exp_und);
    chk({tag, "_frm0"}, sel ? frm_l : frm, 1'b0);
    if ((sel ? en_l : en) === 1'b1) n_en++;
    step();
    chk({tag, "_en_pulse"},  sel ? en_l  : en,  1'b0);
    chk({tag, "_und_pulse"}, sel ? und_l : und, 1'b0);
    chk({tag, "_frm1"}, sel ? frm_l : frm, exp_frm);
    step();
    chk({tag, "_frm2"}, sel ? frm_l : frm, 1'b0);
    step();
  endtask

  // In DONE: one tick returns the line to idle, then acknowledge.
  task automatic finish_frame(input string tag, input bit sel);
    chk({tag, "_done_busy"}, sel ? busy_l : busy, 1'b1);
    chk({tag, "_done_rdy"},  sel ? ld_ready_l : ld_ready, 1'b0);
    chk({tag, "_done_intl"}, sel ? intl_l : intl, 1'b0);
    tick_chk({tag, "_done_tick"}, sel, 1'b0, 1'b0, 1'b0, 1'b0);
    chk({tag, "_done_hold"}, sel ? busy_l : busy, 1'b1);
    tx_success = 1'b1;
    step();
    tx_success = 1'b0;
    chk({tag, "_idle_intl"}, sel ? intl_l : intl, 1'b1);
    chk({tag, "_idle_busy"}, sel ? busy_l : busy, 1'b0);
    chk({tag, "_idle_rdy"},  sel ? ld_ready_l : ld_ready, 1'b1);
    step();
  endtask

  initial begin
    // ---------------- Power-on reset (asynchronous, no clock edge yet)
    #2 g_rst_n = 1'b0;
    #1;
    chk("rst_ser",   ser,      1'b0);
    chk("rst_intl",  intl,     1'b1);
    chk("rst_rdy",   ld_ready, 1'b1);
    chk("rst_en",    en,       1'b0);
    chk("rst_frm",   frm,      1'b0);
    chk("rst_und",   und,      1'b0);
    chk("rst_busy",  busy,     1'b0);
    chk("rst_intl_l", intl_l,  1'b1);
    step(3);
    g_rst_n = 1'b1;
    step(2);
    chk("post_rst_busy", busy, 1'b0);

    // ---------------- Single 44-bit word, len=0 saturates to 44
    w44  = 44'hA55_A5A5_A5A5;
    n_en = 0;
    load_word("w44", 1'b0, w44, 6'd0, 1'b1);
    step(2);
    chk("w44_shift_intl", intl, 1'b0);
    chk("w44_shift_busy", busy, 1'b1);
    chk("w44_shift_rdy",  ld_ready, 1'b1);
    for (int i = 0; i < 44; i++) begin
      tick_chk($sformatf("w44_b%0d", i), 1'b0, w44[43-i], 1'b1, 1'b0, (i == 43));
    end
    chk_int("w44_en_count", n_en, 44);
    finish_frame("w44", 1'b0);

    // ---------------- Back-to-back: 3'b110 then 2'b01 (last)
    load_word("b2b_a", 1'b0, 44'h6, 6'd3, 1'b0);
    load_word("b2b_b", 1'b0, 44'h1, 6'd2, 1'b1);
    chk("b2b_hold_full_rdy", ld_ready, 1'b0);
    tick_chk("b2b_0", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    tick_chk("b2b_1", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    tick_chk("b2b_2", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick_chk("b2b_3", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick_chk("b2b_4", 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    finish_frame("b2b", 1'b0);

    // ---------------- LSB-first instance: 4'b0001 -> 1,0,0,0
    load_word("lsb", 1'b1, 44'h1, 6'd4, 1'b1);
    step(2);
    chk("lsb_busy", busy_l, 1'b1);
    chk("lsb_msb_idle", busy, 1'b0);
    tick_chk("lsb_0", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    tick_chk("lsb_1", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    tick_chk("lsb_2", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    tick_chk("lsb_3", 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    finish_frame("lsb", 1'b1);

    // ---------------- Underrun: len=2 2'b01 non-last, then a third tick
    load_word("und_a", 1'b0, 44'h1, 6'd2, 1'b0);
    step(2);
    tick_chk("und_0", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick_chk("und_1", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    tick_chk("und_2", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("und_busy", busy, 1'b1);
    load_word("und_b", 1'b0, 44'h1, 6'd1, 1'b1);
    step();
    chk("und_reload_rdy", ld_ready, 1'b1);
    tick_chk("und_resume", 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    finish_frame("und", 1'b0);

    // ---------------- Abort at the 10th bit of a 44-bit word (len=50 saturates)
    w44 = 44'h123_4567_89AB;
    load_word("abt", 1'b0, w44, 6'd50, 1'b1);
    step(2);
    for (int i = 0; i < 9; i++) begin
      tick_chk($sformatf("abt_b%0d", i), 1'b0, w44[43-i], 1'b1, 1'b0, 1'b0);
    end
    bit_tick = 1'b1;
    tx_abort = 1'b1;
    ld_valid = 1'b1;
    ld_data  = 44'hFFF;
    ld_len   = 6'd4;
    ld_last  = 1'b1;
    step();
    bit_tick = 1'b0;
    tx_abort = 1'b0;
    ld_valid = 1'b0;
    chk("abt_en",   en,       1'b0);
    chk("abt_ser",  ser,      1'b0);
    chk("abt_intl", intl,     1'b1);
    chk("abt_busy", busy,     1'b0);
    chk("abt_rdy",  ld_ready, 1'b1);
    chk("abt_frm",  frm,      1'b0);
    step();
    chk("abt_no_accept_busy", busy, 1'b0);
    chk("abt_frm_b", frm, 1'b0);
    step(2);
    chk("abt_frm_c", frm, 1'b0);
    load_word("abt_next", 1'b0, 44'h9, 6'd4, 1'b1);
    step(2);
    tick_chk("abt_n0", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    tick_chk("abt_n1", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick_chk("abt_n2", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick_chk("abt_n3", 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    finish_frame("abt_next", 1'b0);

    // ---------------- Reset mid-SHIFT with the holding buffer full
    load_word("mrst_a", 1'b0, 44'hC, 6'd4, 1'b0);
    load_word("mrst_b", 1'b0, 44'h0, 6'd4, 1'b1);
    chk("mrst_pre_rdy", ld_ready, 1'b0);
    bit_tick = 1'b1;
    step();
    bit_tick = 1'b0;
    chk("mrst_pre_ser", ser, 1'b1);
    chk("mrst_pre_en",  en,  1'b1);
    g_rst_n = 1'b0;
    #1;
    chk("mrst_ser",  ser,      1'b0);
    chk("mrst_en",   en,       1'b0);
    chk("mrst_intl", intl,     1'b1);
    chk("mrst_busy", busy,     1'b0);
    chk("mrst_rdy",  ld_ready, 1'b1);
    chk("mrst_frm",  frm,      1'b0);
    chk("mrst_und",  und,      1'b0);
    step(2);
    g_rst_n = 1'b1;
    step(2);
    chk("mrst_after_busy", busy, 1'b0);
    chk("mrst_after_intl", intl, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
